spi_controller: RTL and testbench
=================================

Name: spi_controller

Overview:
- Byte-oriented SPI controller (initiator) that drives SCLK, MOSI and active-low CS toward the on-chip/off-chip SPI target, and captures MISO.
- SPI framing: SCLK idles low, MSB first. The target samples MOSI on SCLK falling and updates MISO after SCLK rising.
- Accepts bytes over a valid/ready interface and supports multi-byte bursts with CS held low. Returns each received byte with a one-cycle strobe.
- All SPI timing is derived from the single system clock by a programmable half-period counter.

Parameters:
HALF_PERIOD, 8, system clock cycles per SCLK half period; legal range 4..255. Must cover the target's input sync plus edge-detect latency plus the local MISO sync.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset, synchronous, active-low
tx_data_i  in  8  byte to transmit
tx_valid_i  in  1  tx_data_i/tx_last_i valid
tx_last_i  in  1  byte is last of burst; CS released after it
tx_ready_o  out  1  controller accepts byte this cycle
rx_data_o  out  8  last byte received on MISO
rx_stb_o  out  1  one-cycle pulse, rx_data_o updated
busy_o  out  1  transfer in progress (state != IDLE)
spi_sclk_o  out  1  SPI clock
spi_mosi_o  out  1  SPI data out
spi_miso_i  in  1  SPI data in (asynchronous)
spi_cs_o  out  1  chip select, active low

Behaviour:
- One clock, clk_i; reset is synchronous and active-low on rst_ni.
- Reset values: spi_cs_o=1, spi_sclk_o=0, spi_mosi_o=0, rx_data_o=0, rx_stb_o=0, busy_o=0, tx_ready_o=1 (IDLE).
- spi_miso_i passes through a 2-FF synchronizer (synchronizer, FF_COUNT=2) before use.
- Registers: half-period counter of width $clog2(HALF_PERIOD+1), 3-bit bit counter, 8-bit tx shift register, 8-bit rx shift register, last-flag register.
- tx_ready_o=1 only in IDLE and WAIT_NEXT. A byte is accepted when tx_valid_i && tx_ready_o. Acceptance latches tx_data_i and tx_last_i.
- FSM states: IDLE, SETUP, HIGH, LOW, WAIT_NEXT, HOLD, GAP.
  - IDLE: CS=1, SCLK=0. On accept -> SETUP.
  - SETUP: CS=0, MOSI=tx bit7, SCLK=0, lasts HALF_PERIOD cycles -> HIGH.
  - HIGH: SCLK=1. On entry MOSI=current tx bit (MSB first). MOSI stays stable through the following LOW phase. Lasts HALF_PERIOD cycles. In the final HIGH cycle, the synchronized MISO shifts into the rx register LSB -> LOW.
  - LOW: SCLK=0 for HALF_PERIOD cycles. If bit counter != 7: increment and go to HIGH. If bit counter == 7: byte done, clear counter.
  - Byte done: the next cycle has rx_stb_o=1 with rx_data_o = full received byte. State goes to HOLD if last=1, else WAIT_NEXT.
  - WAIT_NEXT: CS stays 0, SCLK=0, no time limit. On accept -> SETUP.
  - HOLD: CS=0 for HALF_PERIOD cycles, then CS=1 -> GAP.
  - GAP: CS=1 for HALF_PERIOD cycles -> IDLE (guarantees minimum CS-high time).
- Timing: byte accepted at cycle T:
  - CS falls at T+1.
  - First SCLK rise at T+1+HALF_PERIOD.
  - rx_stb_o at T+1+17*HALF_PERIOD.
  - Each byte therefore occupies 17*HALF_PERIOD+1 cycles from acceptance to strobe.
- tx_valid_i while busy outside WAIT_NEXT: ignored (ready=0). Data must be held by the source.
- tx_valid_i deasserting in WAIT_NEXT: controller waits with CS low. The burst ends only via tx_last_i.
- Reset asserted mid-byte: next cycle all outputs return to reset values. CS rises immediately and the partial rx byte is discarded (no strobe).
- Bit order on both lines MSB first. rx_data_o holds its value until the next strobe.

Test Plan:
- Single byte, HALF_PERIOD=8: send 0xA5 last=1 with a target model returning 0x3C.
  -> MOSI sequence 1,0,1,0,0,1,0,1 sampled at SCLK falls.
  -> rx_stb_o at T+137 with rx_data_o=0x3C.
  -> 8 SCLK pulses; CS high at T+146.
- Burst: 0x01 (last=0), 0x80 (last=0), 0xFF (last=1), loopback MISO=MOSI.
  -> CS low continuously across all three bytes; three strobes returning 0x01, 0x80, 0xFF.
  -> CS rises only after the third byte.
- Backpressure: hold tx_valid_i=1 with 0x55 during an active byte.
  -> tx_ready_o=0 until WAIT_NEXT or IDLE; exactly one acceptance per byte; no duplicate transfer.
- WAIT_NEXT stall: after byte 0x12 with last=0, keep tx_valid_i=0 for 200 cycles.
  -> CS stays 0, SCLK stays 0, busy_o=1; then sending 0x34 last=1 completes normally.
- Reset mid-transfer: assert rst_ni=0 during the 4th HIGH phase.
  -> Next cycle CS=1, SCLK=0, MOSI=0, no rx_stb_o, rx_data_o=0.
  -> A new byte 0x0F then transfers correctly.
- HALF_PERIOD=4 build: repeat the single-byte test.
  -> Strobe at T+69; SCLK high and low phases each exactly 4 cycles.

Source files
------------

// File: rtl/spi_controller.sv
// Byte-oriented SPI initiator: SCLK idles low, MSB first, CS held low across a burst
// until a byte flagged tx_last_i completes. All SPI timing comes from a half-period counter.
module spi_controller #(
    parameter int HALF_PERIOD = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    input  logic       tx_last_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_stb_o,
    output logic       busy_o,
    output logic       spi_sclk_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i,
    output logic       spi_cs_o
);

    localparam int SYNC_FF_COUNT = 2;
    localparam int CW = $clog2(HALF_PERIOD + 1);
    localparam logic [CW-1:0] HP_LAST = CW'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, WAIT_NEXT, HOLD, GAP} state_e;

    state_e                   state_q;
    logic [CW-1:0]            hp_cnt_q, hp_cnt_d;
    logic [2:0]               bit_cnt_q;
    logic [7:0]               tx_shift_q, rx_shift_q, rx_shift_d, rx_data_q;
    logic                     last_q, done_q, rx_stb_q, sclk_q, mosi_q, cs_q;
    logic [SYNC_FF_COUNT-1:0] miso_sync_q;
    logic                     hp_done, accept;

    // spi_miso_i is asynchronous to clk_i; only the last stage is ever used.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) miso_sync_q <= '0;
        else         miso_sync_q <= {miso_sync_q[SYNC_FF_COUNT-2:0], spi_miso_i};
    end

    assign hp_done    = (hp_cnt_q == HP_LAST);
    assign hp_cnt_d   = hp_done ? '0 : hp_cnt_q + CW'(1);
    assign rx_shift_d = {rx_shift_q[6:0], miso_sync_q[SYNC_FF_COUNT-1]};
    assign tx_ready_o = (state_q == IDLE) || (state_q == WAIT_NEXT);
    assign accept     = tx_valid_i && tx_ready_o;

    // NOTE: every register here, shift registers included, is cleared by the synchronous
    // reset and updated only with non-blocking assignments so all state moves on one edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            hp_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_stb_q   <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_q       <= 1'b1;
        end else begin
            rx_stb_q <= 1'b0;
            case (state_q)
                IDLE, WAIT_NEXT: begin
                    if (accept) begin
                        tx_shift_q <= tx_data_i;
                        last_q     <= tx_last_i;
                        mosi_q     <= tx_data_i[7];
                        cs_q       <= 1'b0;
                        hp_cnt_q   <= '0;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    hp_cnt_q <= hp_cnt_d;
                    if (hp_done) begin
                        sclk_q  <= 1'b1;
                        mosi_q  <= tx_shift_q[7];
                        state_q <= HIGH;
                    end
                end
                HIGH: begin
                    hp_cnt_q <= hp_cnt_d;
                    if (hp_done) begin
                        sclk_q     <= 1'b0;
                        rx_shift_q <= rx_shift_d;
                        tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                        state_q    <= LOW;
                    end
                end
                LOW: begin
                    // done_q marks the strobe cycle that follows the eighth low phase.
                    if (done_q) begin
                        done_q  <= 1'b0;
                        state_q <= last_q ? HOLD : WAIT_NEXT;
                    end else begin
                        hp_cnt_q <= hp_cnt_d;
                        if (hp_done) begin
                            if (bit_cnt_q == 3'd7) begin
                                bit_cnt_q <= '0;
                                done_q    <= 1'b1;
                                rx_stb_q  <= 1'b1;
                                rx_data_q <= rx_shift_q;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                sclk_q    <= 1'b1;
                                mosi_q    <= tx_shift_q[7];
                                state_q   <= HIGH;
                            end
                        end
                    end
                end
                HOLD: begin
                    hp_cnt_q <= hp_cnt_d;
                    if (hp_done) begin
                        cs_q    <= 1'b1;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    hp_cnt_q <= hp_cnt_d;
                    if (hp_done) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data_o  = rx_data_q;
    assign rx_stb_o   = rx_stb_q;
    assign busy_o     = (state_q != IDLE);
    assign spi_sclk_o = sclk_q;
    assign spi_mosi_o = mosi_q;
    assign spi_cs_o   = cs_q;

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: an SPI target model plus timing expectations
// derived from the framing rules, run on HALF_PERIOD=8 and HALF_PERIOD=4 instances.
`timescale 1ns/1ps
module tb_spi_controller;

    logic       clk = 1'b0;
    logic       rst_n, tx_valid, tx_last, loopback, sel, tgt_miso, miso;
    logic [7:0] tx_data;
    int         cyc = 0;

    logic [7:0] rx_data8, rx_data4, rx_data_obs;
    logic       stb8, stb4, ready8, ready4, busy8, busy4, sclk8, sclk4, mosi8, mosi4, cs8, cs4;
    logic       stb_obs, ready_obs, busy_obs, sclk_obs, mosi_obs, cs_obs;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_controller #(.HALF_PERIOD(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
        .tx_last_i(tx_last), .tx_ready_o(ready8), .rx_data_o(rx_data8), .rx_stb_o(stb8),
        .busy_o(busy8), .spi_sclk_o(sclk8), .spi_mosi_o(mosi8), .spi_miso_i(miso),
        .spi_cs_o(cs8));

    spi_controller #(.HALF_PERIOD(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
        .tx_last_i(tx_last), .tx_ready_o(ready4), .rx_data_o(rx_data4), .rx_stb_o(stb4),
        .busy_o(busy4), .spi_sclk_o(sclk4), .spi_mosi_o(mosi4), .spi_miso_i(miso),
        .spi_cs_o(cs4));

    assign rx_data_obs = sel ? rx_data4 : rx_data8;
    assign stb_obs     = sel ? stb4     : stb8;
    assign ready_obs   = sel ? ready4   : ready8;
    assign busy_obs    = sel ? busy4    : busy8;
    assign sclk_obs    = sel ? sclk4    : sclk8;
    assign mosi_obs    = sel ? mosi4    : mosi8;
    assign cs_obs      = sel ? cs4      : cs8;
    assign miso        = loopback ? mosi_obs : tgt_miso;

    function automatic int hp();
        return sel ? 4 : 8;
    endfunction

    int n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Target model and bus monitor, sampled on the falling clock edge.
    logic [7:0] reply_q[$], tgt_rx_q[$], stb_d_q[$];
    int         stb_t_q[$];
    logic [7:0] cur_reply = '0, tgt_sh = '0;
    logic [2:0] rise_idx = '0;
    int         fall_idx = 0, rise_total = 0, acc_cnt = 0, cs_rise_cnt = 0;
    int         last_cs_fall = -1, last_first_rise = -1;
    int         run = 0, hi_runs = 0, lo_runs = 0, bad_hi = 0, bad_lo = 0;
    logic       prev_cs = 1'b1, prev_sclk = 1'b0, lo_valid = 1'b0;

    initial begin
        tgt_miso = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_valid && ready_obs && rst_n) acc_cnt++;
            if (stb_obs) begin
                stb_t_q.push_back(cyc);
                stb_d_q.push_back(rx_data_obs);
                lo_valid = 1'b0;
            end
            if (!prev_cs && cs_obs) cs_rise_cnt++;
            if (prev_cs && !cs_obs) begin
                rise_idx = '0; fall_idx = 0; tgt_sh = '0; last_cs_fall = cyc;
            end
            if (!cs_obs && !prev_sclk && sclk_obs) begin
                if (rise_idx == 3'd0) begin
                    last_first_rise = cyc;
                    if (reply_q.size() != 0) cur_reply = reply_q.pop_front();
                    else cur_reply = 8'h00;
                end
                tgt_miso = cur_reply[3'd7 - rise_idx];
                rise_idx = rise_idx + 3'd1;
                rise_total++;
            end
            if (!cs_obs && prev_sclk && !sclk_obs) begin
                tgt_sh = {tgt_sh[6:0], mosi_obs};
                fall_idx++;
                if (fall_idx == 8) begin
                    tgt_rx_q.push_back(tgt_sh);
                    fall_idx = 0;
                end
            end
            if (sclk_obs != prev_sclk) begin
                if (!rst_n) lo_valid = 1'b0;
                else if (prev_sclk) begin
                    hi_runs++;
                    if (run != hp()) bad_hi++;
                end else if (lo_valid) begin
                    lo_runs++;
                    if (run != hp()) bad_lo++;
                end
                lo_valid = prev_sclk && rst_n;
                run = 1;
            end else run++;
            prev_cs = cs_obs;
            prev_sclk = sclk_obs;
        end
    end

    task automatic send(input logic [7:0] d, input logic l, output int t_acc);
        @(posedge clk); #1;
        tx_data = d; tx_last = l; tx_valid = 1'b1; t_acc = -1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (ready_obs) begin
                t_acc = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
        check("accept_seen", 32'(t_acc >= 0), 1);
    endtask

    task automatic check_byte(input string tag, input int t_acc, input logic [7:0] d,
                              input logic [7:0] exp_rx, output int t_stb);
        logic [7:0] got_rx, got_mosi;
        t_stb = -1;
        for (int i = 0; i < 4000 && stb_t_q.size() == 0; i++) @(negedge clk);
        if (stb_t_q.size() == 0) begin
            check({tag, "_stb_timeout"}, 32'(stb_t_q.size()), 1);
            return;
        end
        t_stb  = stb_t_q.pop_front();
        got_rx = stb_d_q.pop_front();
        if (tgt_rx_q.size() != 0) got_mosi = tgt_rx_q.pop_front();
        else got_mosi = 8'hxx;
        check({tag, "_stb_cycle"}, t_stb, t_acc + 1 + 17 * hp());
        check({tag, "_rx_data"}, 32'(got_rx), 32'(exp_rx));
        check({tag, "_mosi_byte"}, 32'(got_mosi), 32'(d));
    endtask

    task automatic wait_cs_high(input string tag, input int t_stb);
        int t_cs;
        t_cs = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (cs_obs) begin
                t_cs = cyc;
                break;
            end
        end
        check({tag, "_cs_rise_cycle"}, t_cs, t_stb + hp() + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int         t, t2, ts, a0, c0, r0, h0, l0, bad, len, gap;
    logic [7:0] d, rep;

    initial begin
        rst_n = 1'b0; tx_valid = 1'b0; tx_last = 1'b0; tx_data = '0;
        loopback = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs", 32'(cs_obs), 1);
        check("rst_sclk", 32'(sclk_obs), 0);
        check("rst_mosi", 32'(mosi_obs), 0);
        check("rst_rx_data", 32'(rx_data_obs), 0);
        check("rst_stb", 32'(stb_obs), 0);
        check("rst_busy", 32'(busy_obs), 0);
        check("rst_ready", 32'(ready_obs), 1);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single byte with target reply
        reply_q.push_back(8'h3C); r0 = rise_total;
        send(8'hA5, 1'b1, t);
        check_byte("single", t, 8'hA5, 8'h3C, ts);
        check("single_cs_fall", last_cs_fall, t + 1);
        check("single_first_rise", last_first_rise, t + 1 + hp());
        wait_cs_high("single", ts);
        check("single_sclk_pulses", rise_total - r0, 8);

        // Loopback burst, CS held across bytes
        loopback = 1'b1; c0 = cs_rise_cnt;
        send(8'h01, 1'b0, t); check_byte("burst0", t, 8'h01, 8'h01, ts);
        send(8'h80, 1'b0, t); check_byte("burst1", t, 8'h80, 8'h80, ts);
        send(8'hFF, 1'b1, t); check_byte("burst2", t, 8'hFF, 8'hFF, ts);
        check("burst_cs_held", cs_rise_cnt - c0, 0);
        wait_cs_high("burst", ts);
        check("burst_cs_rises", cs_rise_cnt - c0, 1);
        loopback = 1'b0;

        // Backpressure: second byte held valid throughout the first
        reply_q.push_back(8'hE7); reply_q.push_back(8'h18); a0 = acc_cnt;
        send(8'hC9, 1'b0, t);
        send(8'h55, 1'b1, t2);
        check("bp_accept_cycle", t2, t + 2 + 17 * hp());
        check_byte("bp0", t, 8'hC9, 8'hE7, ts);
        check_byte("bp1", t2, 8'h55, 8'h18, ts);
        wait_cs_high("bp", ts);
        repeat (20) @(negedge clk);
        check("bp_accepts", acc_cnt - a0, 2);
        check("bp_no_extra_stb", 32'(stb_t_q.size()), 0);

        // WAIT_NEXT stall
        reply_q.push_back(8'hA1); reply_q.push_back(8'h5A);
        send(8'h12, 1'b0, t); check_byte("wait0", t, 8'h12, 8'hA1, ts);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (cs_obs !== 1'b0 || sclk_obs !== 1'b0 || busy_obs !== 1'b1 || ready_obs !== 1'b1)
                bad++;
        end
        check("wait_stall_violations", bad, 0);
        send(8'h34, 1'b1, t); check_byte("wait1", t, 8'h34, 8'h5A, ts);
        wait_cs_high("wait1", ts);

        // Reset during the fourth high phase
        reply_q.push_back(8'h99); r0 = rise_total;
        send(8'hD6, 1'b1, t);
        for (int i = 0; i < 2000 && rise_total < r0 + 4; i++) @(negedge clk);
        check("rst_reached_4th_high", rise_total - r0, 4);
        @(negedge clk);
        check("rst_pre_sclk", 32'(sclk_obs), 1);
        check("rst_pre_mosi", 32'(mosi_obs), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_cs", 32'(cs_obs), 1);
        check("midrst_sclk", 32'(sclk_obs), 0);
        check("midrst_mosi", 32'(mosi_obs), 0);
        check("midrst_stb", 32'(stb_obs), 0);
        check("midrst_rx_data", 32'(rx_data_obs), 0);
        check("midrst_busy", 32'(busy_obs), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_no_stb", 32'(stb_t_q.size()), 0);
        check("midrst_no_partial", 32'(tgt_rx_q.size()), 0);
        reply_q.push_back(8'hC3);
        send(8'h0F, 1'b1, t); check_byte("post_rst", t, 8'h0F, 8'hC3, ts);
        wait_cs_high("post_rst", ts);

        // Randomized bursts with random stalls between bytes
        for (int b = 0; b < 5; b++) begin
            len = int'($urandom_range(1, 3));
            for (int k = 0; k < len; k++) begin
                d = 8'($urandom); rep = 8'($urandom);
                reply_q.push_back(rep);
                send(d, k == len - 1, t);
                check_byte("rnd", t, d, rep, ts);
                if (k == len - 1) wait_cs_high("rnd", ts);
                else begin
                    gap = int'($urandom_range(0, 15));
                    repeat (gap) @(negedge clk);
                end
            end
        end

        // HALF_PERIOD=4 instance
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sel = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        h0 = hi_runs; l0 = lo_runs;
        reply_q.push_back(8'h3C);
        send(8'hA5, 1'b1, t);
        check_byte("hp4", t, 8'hA5, 8'h3C, ts);
        wait_cs_high("hp4", ts);
        check("hp4_high_phases", hi_runs - h0, 8);
        check("hp4_low_phases", lo_runs - l0, 7);
        check("sclk_high_len_errors", bad_hi, 0);
        check("sclk_low_len_errors", bad_lo, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
